// File: rtl/rv32i_types.sv
// Shared rv32i pipeline types: opcodes, control-word fields, immediate formats
// and the ID/EX register layout. Also holds the immediate generator.
package rv32i_types;

  localparam int          NUM_REGS  = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011
  } rv32i_opcode_t;

  typedef enum logic [2:0] {
    alu_add = 3'd0, alu_sll = 3'd1, alu_sra = 3'd2, alu_sub = 3'd3,
    alu_xor = 3'd4, alu_srl = 3'd5, alu_or  = 3'd6, alu_and = 3'd7
  } alu_ops_t;

  typedef enum logic [2:0] {
    cmp_beq  = 3'b000, cmp_bne  = 3'b001, cmp_blt  = 3'b100,
    cmp_bge  = 3'b101, cmp_bltu = 3'b110, cmp_bgeu = 3'b111
  } cmp_ops_t;

  typedef enum logic { alumux1_rs1 = 1'b0, alumux1_pc  = 1'b1 } alumux1_sel_t;
  typedef enum logic { alumux2_imm = 1'b0, alumux2_rs2 = 1'b1 } alumux2_sel_t;

  typedef enum logic [2:0] {
    rfmux_alu = 3'd0, rfmux_br_en = 3'd1, rfmux_u_imm = 3'd2,
    rfmux_load = 3'd3, rfmux_pc_plus4 = 3'd4
  } regfilemux_sel_t;

  typedef enum logic [2:0] {
    imm_none, imm_i, imm_s, imm_b, imm_u, imm_j
  } imm_fmt_t;

  typedef struct packed {
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    alu_ops_t        aluop;
    cmp_ops_t        cmpop;
    alumux1_sel_t    alumux1_sel;
    alumux2_sel_t    alumux2_sel;
    regfilemux_sel_t regfilemux_sel;
    logic            load_regfile;
    logic            mem_read;
    logic            mem_write;
    logic            illegal;
  } ctrl_word_t;

  typedef struct packed {
    logic [31:0] pc;
    ctrl_word_t  ctrl;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        valid;
    logic        false_nop;
  } id_ex_t;

  function automatic logic [31:0] imm_gen(input logic [31:0] instr, input imm_fmt_t fmt);
    case (fmt)
      imm_i:   return {{20{instr[31]}}, instr[31:20]};
      imm_s:   return {{20{instr[31]}}, instr[31:25], instr[11:7]};
      imm_b:   return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      imm_u:   return {instr[31:12], 12'b0};
      imm_j:   return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: return 32'b0;
    endcase
  endfunction

  // alt selects sub/sra; callers only raise it where funct7[5] is meaningful.
  function automatic alu_ops_t alu_from_funct3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? alu_sub : alu_add;
      3'b001:  return alu_sll;
      3'b100:  return alu_xor;
      3'b101:  return alt ? alu_sra : alu_srl;
      3'b110:  return alu_or;
      3'b111:  return alu_and;
      default: return alu_add;
    endcase
  endfunction

  function automatic cmp_ops_t cmp_from_funct3(input logic [2:0] f3);
    case (f3)
      3'b001:  return cmp_bne;
      3'b100:  return cmp_blt;
      3'b101:  return cmp_bge;
      3'b110:  return cmp_bltu;
      3'b111:  return cmp_bgeu;
      default: return cmp_beq;
    endcase
  endfunction

endpackage

// File: rtl/id_regfile.sv
// 32x32 register file, two combinational read ports, one write port, x0 = 0.
// Optional write-to-read bypass under macro REGFILE_BYPASS_EN.
module id_regfile
  import rv32i_types::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2
);

  logic [31:0] regs_q [NUM_REGS];
  logic [31:0] regs_d [NUM_REGS];

  always_comb begin
    regs_d = regs_q;
    if (we && waddr != 5'd0) regs_d[waddr] = wdata;
  end

  // NOTE: the array is cleared in reset because architectural state must read 0
  // after reset; this forces flops rather than a RAM macro, which is accepted here.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  function automatic logic [31:0] read_port(input logic [4:0] addr);
    if (addr == 5'd0) return 32'b0;
`ifdef REGFILE_BYPASS_EN
    if (we && addr == waddr) return wdata;
`endif
    return regs_q[addr];
  endfunction

  always_comb rdata1 = read_port(raddr1);
  always_comb rdata2 = read_port(raddr2);

endmodule

// File: rtl/instruction_decode.sv
// rv32i ID stage: decode, register read, load-use bubble, ID/EX register.
// Build option REGFILE_BYPASS_EN enables same-cycle WB->ID bypass in id_regfile.
module instruction_decode
  import rv32i_types::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_ff,
  input  logic [31:0] instr_ff,
  input  logic        false_NOP,
  input  logic        MA_stall,
  input  logic        br_taken,
  input  logic        wb_load,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic        bubble,
  output logic [31:0] ex_pc,
  output ctrl_word_t  ex_ctrl,
  output logic [31:0] ex_rs1_data,
  output logic [31:0] ex_rs2_data,
  output logic [31:0] ex_imm,
  output logic [4:0]  ex_rs1,
  output logic [4:0]  ex_rs2,
  output logic [4:0]  ex_rd,
  output logic        ex_valid,
  output logic        ex_false_nop
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rs1, rs2, rd;
  ctrl_word_t  ctrl;
  imm_fmt_t    imm_fmt;
  logic        rs1_used, rs2_used, load_use;
  logic [31:0] rs1_data, rs2_data;
  id_ex_t      id_ex_q, id_ex_d;

  assign opcode = instr_ff[6:0];
  assign rd     = instr_ff[11:7];
  assign funct3 = instr_ff[14:12];
  assign rs1    = instr_ff[19:15];
  assign rs2    = instr_ff[24:20];

  id_regfile u_regfile (
    .clk    (clk),
    .rst    (rst),
    .we     (wb_load),
    .waddr  (wb_rd),
    .wdata  (wb_data),
    .raddr1 (rs1),
    .raddr2 (rs2),
    .rdata1 (rs1_data),
    .rdata2 (rs2_data)
  );

  always_comb begin
    // NOTE: defaults first so every path assigns every field and no latch is inferred.
    ctrl        = '0;
    imm_fmt     = imm_none;
    ctrl.opcode = opcode;
    ctrl.funct3 = funct3;
    case (opcode)
      op_lui:   begin imm_fmt = imm_u; ctrl.load_regfile = 1'b1; ctrl.regfilemux_sel = rfmux_u_imm; end
      op_auipc: begin imm_fmt = imm_u; ctrl.load_regfile = 1'b1; ctrl.alumux1_sel = alumux1_pc; end
      op_jal: begin
        imm_fmt = imm_j; ctrl.load_regfile = 1'b1;
        ctrl.alumux1_sel = alumux1_pc; ctrl.regfilemux_sel = rfmux_pc_plus4;
      end
      op_jalr:  begin imm_fmt = imm_i; ctrl.load_regfile = 1'b1; ctrl.regfilemux_sel = rfmux_pc_plus4; end
      op_br:    begin imm_fmt = imm_b; ctrl.alumux1_sel = alumux1_pc; ctrl.cmpop = cmp_from_funct3(funct3); end
      op_load: begin
        imm_fmt = imm_i; ctrl.load_regfile = 1'b1;
        ctrl.mem_read = 1'b1; ctrl.regfilemux_sel = rfmux_load;
      end
      op_store: begin imm_fmt = imm_s; ctrl.mem_write = 1'b1; end
      op_imm, op_reg: begin
        imm_fmt           = (opcode == op_imm) ? imm_i : imm_none;
        ctrl.load_regfile = 1'b1;
        ctrl.alumux2_sel  = (opcode == op_reg) ? alumux2_rs2 : alumux2_imm;
        // slt/sltu reuse the comparator and write its flag back
        if (funct3 == 3'b010 || funct3 == 3'b011) begin
          ctrl.cmpop          = funct3[0] ? cmp_bltu : cmp_blt;
          ctrl.regfilemux_sel = rfmux_br_en;
        end else begin
          ctrl.aluop = alu_from_funct3(funct3, instr_ff[30] &&
                                       (opcode == op_reg || funct3 == 3'b101));
        end
      end
      default: begin ctrl = '0; ctrl.illegal = 1'b1; end
    endcase
  end

  assign rs1_used = !(opcode inside {op_lui, op_auipc, op_jal});
  assign rs2_used = opcode inside {op_br, op_store, op_reg};

  assign load_use = id_ex_q.valid && id_ex_q.ctrl.mem_read && (id_ex_q.rd != 5'd0) &&
                    ((rs1_used && rs1 == id_ex_q.rd) || (rs2_used && rs2 == id_ex_q.rd)) &&
                    !br_taken;
  assign bubble   = load_use;

  always_comb begin
    id_ex_d = id_ex_q;
    if (MA_stall) begin
      id_ex_d = id_ex_q;
    end else if (br_taken || load_use) begin
      id_ex_d           = '0;
      id_ex_d.false_nop = 1'b1;
    end else begin
      id_ex_d.pc        = pc_ff;
      id_ex_d.ctrl      = ctrl;
      id_ex_d.rs1_data  = rs1_data;
      id_ex_d.rs2_data  = rs2_data;
      id_ex_d.imm       = imm_gen(instr_ff, imm_fmt);
      id_ex_d.rs1       = rs1;
      id_ex_d.rs2       = rs2;
      id_ex_d.rd        = rd;
      id_ex_d.valid     = !false_NOP;
      id_ex_d.false_nop = false_NOP;
    end
  end

  // NOTE: non-blocking assignment so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge clk) begin
    if (rst) id_ex_q <= '0;
    else     id_ex_q <= id_ex_d;
  end

  assign ex_pc        = id_ex_q.pc;
  assign ex_ctrl      = id_ex_q.ctrl;
  assign ex_rs1_data  = id_ex_q.rs1_data;
  assign ex_rs2_data  = id_ex_q.rs2_data;
  assign ex_imm       = id_ex_q.imm;
  assign ex_rs1       = id_ex_q.rs1;
  assign ex_rs2       = id_ex_q.rs2;
  assign ex_rd        = id_ex_q.rd;
  assign ex_valid     = id_ex_q.valid;
  assign ex_false_nop = id_ex_q.false_nop;

endmodule

// File: tb/tb_instruction_decode.sv
// Self-checking bench for instruction_decode: reset, decode table, hazard /
// flush / stall / bypass sequences, then randomized traffic against a model.
module tb_instruction_decode;
  import rv32i_types::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_ff, instr_ff;
  logic        false_NOP, MA_stall, br_taken, wb_load;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        bubble;
  logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  ctrl_word_t  ex_ctrl;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic        ex_valid, ex_false_nop;

  instruction_decode dut (
    .clk(clk), .rst(rst), .pc_ff(pc_ff), .instr_ff(instr_ff), .false_NOP(false_NOP),
    .MA_stall(MA_stall), .br_taken(br_taken), .wb_load(wb_load), .wb_rd(wb_rd),
    .wb_data(wb_data), .bubble(bubble), .ex_pc(ex_pc), .ex_ctrl(ex_ctrl),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_valid(ex_valid),
    .ex_false_nop(ex_false_nop)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    instr_ff = NOP_INSTR; pc_ff = 32'h0; false_NOP = 1'b0;
    MA_stall = 1'b0; br_taken = 1'b0; wb_load = 1'b0; wb_rd = 5'd0; wb_data = 32'h0;
  endtask

  function automatic logic [31:0] enc_r(input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [4:0] rs2);
    return {7'b0, rs2, rs1, 3'b000, rd, 7'h33};
  endfunction

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] pc, imm, d1, d2;
    logic [4:0]  rs1, rs2, rd;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        valid, fnop, ld, mr, mw, ill;
  } mex_t;

  logic [31:0] m_regs [32];
  mex_t        m;

  function automatic logic is_legal(input logic [6:0] op);
    return op inside {7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
  endfunction

  // Immediates built arithmetically from the field positions.
  function automatic logic [31:0] m_imm(input logic [31:0] i);
    int s31, s25, s20;
    s31 = $signed(i) >>> 31;
    s25 = $signed(i) >>> 25;
    s20 = $signed(i) >>> 20;
    case (i[6:0])
      7'h13, 7'h03, 7'h67: return s20;
      7'h23: return s25 * 32 + int'(i[11:7]);
      7'h63: return s31 * 4096 + int'(i[7]) * 2048 + int'(i[30:25]) * 32 + int'(i[11:8]) * 2;
      7'h37, 7'h17: return i & 32'hFFFF_F000;
      7'h6F: return s31 * 1048576 + int'(i[19:12]) * 4096 + int'(i[20]) * 2048 + int'(i[30:21]) * 2;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] r);
    if (r == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (wb_load && wb_rd == r) return wb_data;
`endif
    return m_regs[r];
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops [11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h7F, 7'h0B};
    logic [31:0] r;
    r        = $urandom;
    r[6:0]   = ops[$urandom_range(0, 10)];
    r[11:7]  = 5'($urandom_range(0, 7));
    r[19:15] = 5'($urandom_range(0, 7));
    r[24:20] = 5'($urandom_range(0, 7));
    return r;
  endfunction

  task automatic compare_ex(input string t);
    check({t, "_pc"}, ex_pc, m.pc);
    check({t, "_imm"}, ex_imm, m.imm);
    check({t, "_rs1_data"}, ex_rs1_data, m.d1);
    check({t, "_rs2_data"}, ex_rs2_data, m.d2);
    check({t, "_idx"}, {17'b0, ex_rs1, ex_rs2, ex_rd}, {17'b0, m.rs1, m.rs2, m.rd});
    check({t, "_valid_fnop"}, {30'b0, ex_valid, ex_false_nop}, {30'b0, m.valid, m.fnop});
    check({t, "_op_f3"}, {22'b0, ex_ctrl.opcode, ex_ctrl.funct3}, {22'b0, m.op, m.f3});
    check({t, "_flags"},
          {28'b0, ex_ctrl.load_regfile, ex_ctrl.mem_read, ex_ctrl.mem_write, ex_ctrl.illegal},
          {28'b0, m.ld, m.mr, m.mw, m.ill});
  endtask

  // ---------------- decode table ----------------
  typedef struct {
    logic [31:0] instr, imm;
    logic [4:0]  rd;
    logic        ld, mr, mw, ill;
  } vec_t;

  vec_t vecs [10];

  initial begin
    logic [6:0] op;
    logic       rs1u, rs2u, exp_bub, hold;
    logic [31:0] sw_pc;

    vecs[0] = '{32'h0012_8313, 32'h0000_0001, 5'd6,  1'b1, 1'b0, 1'b0, 1'b0}; // addi x6,x5,1
    vecs[1] = '{32'h1234_50B7, 32'h1234_5000, 5'd1,  1'b1, 1'b0, 1'b0, 1'b0}; // lui
    vecs[2] = '{32'hFE20_AE23, 32'hFFFF_FFFC, 5'd28, 1'b0, 1'b0, 1'b1, 1'b0}; // sw x2,-4(x1)
    vecs[3] = '{32'hFE20_8CE3, 32'hFFFF_FFF8, 5'd25, 1'b0, 1'b0, 1'b0, 1'b0}; // beq x1,x2,-8
    vecs[4] = '{32'h0010_00EF, 32'h0000_0800, 5'd1,  1'b1, 1'b0, 1'b0, 1'b0}; // jal x1,2048
    vecs[5] = '{32'h0000_A383, 32'h0000_0000, 5'd7,  1'b1, 1'b1, 1'b0, 1'b0}; // lw x7,0(x1)
    vecs[6] = '{32'hFFFF_FFFF, 32'h0000_0000, 5'd31, 1'b0, 1'b0, 1'b0, 1'b1}; // illegal
    vecs[7] = '{32'h0023_8433, 32'h0000_0000, 5'd8,  1'b1, 1'b0, 1'b0, 1'b0}; // add x8,x7,x2
    vecs[8] = '{32'h8000_0197, 32'h8000_0000, 5'd3,  1'b1, 1'b0, 1'b0, 1'b0}; // auipc
    vecs[9] = '{32'hFFF0_8067, 32'hFFFF_FFFF, 5'd0,  1'b1, 1'b0, 1'b0, 1'b0}; // jalr x0,-1(x1)

    // 1. reset
    idle();
    rst = 1'b1;
    tick(); tick();
    check("rst_ex_pc", ex_pc, 32'h0);
    check("rst_ex_ctrl", 32'(ex_ctrl), 32'h0);
    check("rst_ex_imm", ex_imm, 32'h0);
    check("rst_ex_data", ex_rs1_data | ex_rs2_data, 32'h0);
    check("rst_ex_idx", {17'b0, ex_rs1, ex_rs2, ex_rd}, 32'h0);
    check("rst_valid_fnop", {30'b0, ex_valid, ex_false_nop}, 32'h0);
    check("rst_bubble", {31'b0, bubble}, 32'h0);
    rst = 1'b0;
    for (int r = 1; r < 32; r++) begin
      instr_ff = enc_r(5'd0, 5'(r), 5'(r));
      tick();
      check($sformatf("rst_read_x%0d", r), ex_rs1_data | ex_rs2_data, 32'h0);
    end

    // decode table
    for (int k = 0; k < 10; k++) begin
      instr_ff = vecs[k].instr;
      pc_ff    = 32'h1000 + 32'(k * 4);
      tick();
      check($sformatf("tbl%0d_imm", k), ex_imm, vecs[k].imm);
      check($sformatf("tbl%0d_rd", k), {27'b0, ex_rd}, {27'b0, vecs[k].rd});
      check($sformatf("tbl%0d_pc", k), ex_pc, 32'h1000 + 32'(k * 4));
      check($sformatf("tbl%0d_flags", k),
            {26'b0, ex_valid, ex_false_nop, ex_ctrl.load_regfile, ex_ctrl.mem_read,
             ex_ctrl.mem_write, ex_ctrl.illegal},
            {26'b0, 1'b1, 1'b0, vecs[k].ld, vecs[k].mr, vecs[k].mw, vecs[k].ill});
    end
    instr_ff = enc_r(5'd3, 5'd1, 5'd2);
    tick();
    check("tbl_add_aluop", 32'(ex_ctrl.aluop), 32'(alu_add));
    instr_ff = {7'b0100000, 5'd2, 5'd1, 3'b000, 5'd3, 7'h33};
    tick();
    check("tbl_sub_aluop", 32'(ex_ctrl.aluop), 32'(alu_sub));
    check("tbl_sub_mux2", 32'(ex_ctrl.alumux2_sel), 32'(alumux2_rs2));

    // 2. write-back then dependent addi
    idle();
    wb_load = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEAD_BEEF;
    tick();
    wb_load = 1'b0;
    instr_ff = 32'h0012_8313; pc_ff = 32'h200;
    tick();
    check("wb_addi_rs1", ex_rs1_data, 32'hDEAD_BEEF);
    check("wb_addi_imm", ex_imm, 32'h1);
    check("wb_addi_valid", {31'b0, ex_valid}, 32'h1);

    // 3. load-use bubble
    instr_ff = 32'h0000_A383;
    tick();
    instr_ff = 32'h0023_8433;
    #1;
    check("lu_bubble_on", {31'b0, bubble}, 32'h1);
    tick();
    check("lu_nop_valid_fnop", {30'b0, ex_valid, ex_false_nop}, 32'h1);
    check("lu_nop_ctrl", 32'(ex_ctrl), 32'h0);
    check("lu_bubble_off", {31'b0, bubble}, 32'h0);
    tick();
    check("lu_add_issued", {26'b0, ex_valid, ex_rd}, {26'b0, 1'b1, 5'd8});

    // 4. branch flush beats a load-use hazard
    instr_ff = 32'h0000_A383;
    tick();
    instr_ff = 32'hFE23_8CE3; br_taken = 1'b1;
    #1;
    check("br_bubble_masked", {31'b0, bubble}, 32'h0);
    tick();
    check("br_flush_valid", {31'b0, ex_valid}, 32'h0);
    check("br_flush_ctrl", 32'(ex_ctrl), 32'h0);
    check("br_flush_fnop", {31'b0, ex_false_nop}, 32'h1);
    br_taken = 1'b0;

    // 5. MA_stall holds ID/EX; WB still writes
    instr_ff = 32'hFE20_AE23; sw_pc = 32'h0000_0340; pc_ff = sw_pc;
    tick();
    MA_stall = 1'b1; instr_ff = enc_r(5'd8, 5'd1, 5'd2); pc_ff = 32'h344;
    wb_load = 1'b1; wb_rd = 5'd3; wb_data = 32'h0000_1234;
    for (int c = 0; c < 3; c++) begin
      tick();
      wb_load = 1'b0;
      check($sformatf("stall%0d_pc", c), ex_pc, sw_pc);
      check($sformatf("stall%0d_imm", c), ex_imm, 32'hFFFF_FFFC);
      check($sformatf("stall%0d_mw_valid", c), {30'b0, ex_ctrl.mem_write, ex_valid}, 32'h3);
    end
    MA_stall = 1'b0;
    instr_ff = enc_r(5'd0, 5'd3, 5'd0);
    tick();
    check("stall_wb_x3", ex_rs1_data, 32'h0000_1234);

    // 6. same-cycle write/read and x0
    wb_load = 1'b1; wb_rd = 5'd9; wb_data = 32'd77;
    tick();
    wb_data = 32'd5;
    instr_ff = enc_r(5'd0, 5'd9, 5'd9);
    tick();
`ifdef REGFILE_BYPASS_EN
    check("same_cycle_x9", ex_rs1_data, 32'd5);
`else
    check("same_cycle_x9", ex_rs1_data, 32'd77);
`endif
    wb_rd = 5'd0; wb_data = 32'hFFFF_FFFF;
    instr_ff = enc_r(5'd0, 5'd0, 5'd0);
    tick();
    check("x0_same_cycle", ex_rs1_data, 32'h0);
    wb_load = 1'b0;
    tick();
    check("x0_after", ex_rs1_data | ex_rs2_data, 32'h0);

    // randomized traffic against the model
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m = '{default: '0};
    for (int r = 0; r < 32; r++) m_regs[r] = 32'h0;
    hold = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (!hold) begin
        instr_ff  = rand_instr();
        pc_ff     = $urandom & 32'hFFFF_FFFC;
        false_NOP = ($urandom_range(0, 7) == 0);
      end
      MA_stall = ($urandom_range(0, 7) == 0);
      br_taken = ($urandom_range(0, 9) == 0);
      wb_load  = 1'($urandom_range(0, 1));
      wb_rd    = 5'($urandom_range(0, 7));
      wb_data  = $urandom;
      #1;
      op   = instr_ff[6:0];
      rs1u = !(op inside {7'h37, 7'h17, 7'h6F});
      rs2u = op inside {7'h63, 7'h23, 7'h33};
      exp_bub = m.valid && m.mr && (m.rd != 0) && !br_taken &&
                ((rs1u && instr_ff[19:15] == m.rd) || (rs2u && instr_ff[24:20] == m.rd));
      check("rnd_bubble", {31'b0, bubble}, {31'b0, exp_bub});
      if (MA_stall) begin
        // ID/EX keeps its contents
      end else if (br_taken || exp_bub) begin
        m = '{default: '0};
        m.fnop = 1'b1;
      end else begin
        m.pc    = pc_ff;
        m.imm   = m_imm(instr_ff);
        m.d1    = m_read(instr_ff[19:15]);
        m.d2    = m_read(instr_ff[24:20]);
        m.rs1   = instr_ff[19:15];
        m.rs2   = instr_ff[24:20];
        m.rd    = instr_ff[11:7];
        m.valid = !false_NOP;
        m.fnop  = false_NOP;
        m.ill   = !is_legal(op);
        m.op    = m.ill ? 7'h0 : op;
        m.f3    = m.ill ? 3'h0 : instr_ff[14:12];
        m.ld    = op inside {7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h33};
        m.mr    = (op == 7'h03);
        m.mw    = (op == 7'h23);
      end
      hold = MA_stall || exp_bub;
      if (wb_load && wb_rd != 0) m_regs[wb_rd] = wb_data;
      tick();
      compare_ex($sformatf("rnd%0d", c));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
